pipelined_weighted_sum: RTL and testbench

//   Binary-input weighted sum for the single-layer perceptron, successor to the N-cycle serial chain.

---
 rtl/nn_pkg.sv | 53 +++++
 rtl/wsum_tree_level.sv | 42 ++++
 rtl/pipelined_weighted_sum.sv | 119 +++++++++++
 tb/tb_pipelined_weighted_sum.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared perceptron definitions: default weight width, weight type,
// a constant-friendly clog2, and the overflow / saturate-or-wrap helpers
// reused by the activation stage.
package nn_pkg;

  localparam int NN_WEIGHT_W  = 32;
  // Widest accumulator the helpers accept; callers sign-extend into it.
  localparam int NN_ACC_MAX_W = 64;

  typedef logic signed [NN_WEIGHT_W-1:0] nn_weight_t;

  // Ceiling log2 usable in parameter expressions; nn_clog2(1) = 0.
  function automatic int nn_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // True when acc does not fit a signed w-bit two's-complement value.
  function automatic logic nn_ovf(input logic signed [NN_ACC_MAX_W-1:0] acc,
                                  input int unsigned w);
    logic signed [NN_ACC_MAX_W-1:0] max_v;
    logic signed [NN_ACC_MAX_W-1:0] min_v;
    max_v = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 32'd1));
    return (acc > max_v) || (acc < min_v);
  endfunction

  // Clamp to the signed w-bit range when sat_en, otherwise pass through so
  // the caller's truncation to w bits gives the two's-complement wrap.
  function automatic logic [NN_ACC_MAX_W-1:0] nn_sat_wrap(
      input logic signed [NN_ACC_MAX_W-1:0] acc,
      input int unsigned w,
      input logic sat_en);
    logic [NN_ACC_MAX_W-1:0] r;
    if (sat_en && nn_ovf(acc, w)) begin
      if (acc[NN_ACC_MAX_W-1]) begin
        r = -(64'sd1 <<< (w - 32'd1));
      end else begin
        r = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
      end
    end else begin
      r = acc;
    end
    return r;
  endfunction

endpackage

// File: rtl/wsum_tree_level.sv
// One register level of the weighted-sum adder tree: PAIRS full-precision
// AW-bit adders plus a valid bit, all loading only when adv is high.
module wsum_tree_level import nn_pkg::*; #(
  parameter int PAIRS = 1,
  parameter int AW    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic                    in_valid,
  input  logic [2*PAIRS*AW-1:0]   in_data,
  output logic                    out_valid,
  output logic [PAIRS*AW-1:0]     out_data
);

  logic [PAIRS*AW-1:0] sum_s;
  logic [PAIRS*AW-1:0] data_r;
  logic                valid_r;

  // Pairwise sums of neighbouring terms; AW already covers the tree growth.
  always_comb begin
    sum_s = '0;
    for (int j = 0; j < PAIRS; j++) begin
      sum_s[j*AW +: AW] = in_data[(2*j)*AW +: AW] + in_data[(2*j+1)*AW +: AW];
    end
  end

  // Level register; the whole pipe freezes together when adv is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (adv) begin
      valid_r <= in_valid;
      data_r  <= sum_s;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/pipelined_weighted_sum.sv
// Pipelined binary-input weighted sum: masked terms, log2(N) registered
// adder levels, then a registered wrap/saturate output stage with overflow
// flag. Valid/ready flow control with a single global advance enable.
// Build option: define WSUM_SATURATE_EN to clamp sum on overflow instead of
// wrapping.
module pipelined_weighted_sum import nn_pkg::*; #(
  parameter int N = 8,
  parameter int W = NN_WEIGHT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [W*N-1:0] w,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   sum,
  output logic           ovf
);

  localparam int LEVELS = nn_clog2(N);
  localparam int NP     = 1 << LEVELS;
  localparam int AW     = W + LEVELS;
  // All levels packed into one vector: NP + NP/2 + ... + 1 terms.
  localparam int TREE_W = AW * (2*NP - 1);

`ifdef WSUM_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // Bit offset of tree level l inside tree_s.
  function automatic int lvl_off(input int l);
    return AW * (2*NP - ((2*NP) >> l));
  endfunction

  logic                          adv_s;
  logic [NP*AW-1:0]              stage0_next_s;
  logic [NP*AW-1:0]              stage0_data_r;
  logic                          stage0_valid_r;
  logic [TREE_W-1:0]             tree_s;
  logic [LEVELS:0]               vld_s;
  logic [AW-1:0]                 final_s;
  logic signed [NN_ACC_MAX_W-1:0] acc_ext_s;
  logic [W-1:0]                  sum_next_s;
  logic                          ovf_next_s;
  logic                          out_valid_r;
  logic [W-1:0]                  sum_r;
  logic                          ovf_r;

  assign adv_s    = !out_valid_r || out_ready;
  assign in_ready = adv_s;

  // Masked, sign-extended terms; padding channels stay zero.
  always_comb begin
    stage0_next_s = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) begin
        stage0_next_s[i*AW +: AW] = AW'($signed(w[W*i +: W]));
      end else begin
        stage0_next_s[i*AW +: AW] = '0;
      end
    end
  end

  // Stage 0 register: a transfer happens whenever in_valid is high under adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage0_valid_r <= 1'b0;
      stage0_data_r  <= '0;
    end else if (adv_s) begin
      stage0_valid_r <= in_valid;
      stage0_data_r  <= stage0_next_s;
    end
  end

  assign tree_s[0 +: NP*AW] = stage0_data_r;
  assign vld_s[0]           = stage0_valid_r;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    wsum_tree_level #(
      .PAIRS (NP >> l),
      .AW    (AW)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv_s),
      .in_valid  (vld_s[l-1]),
      .in_data   (tree_s[lvl_off(l-1) +: 2*(NP >> l)*AW]),
      .out_valid (vld_s[l]),
      .out_data  (tree_s[lvl_off(l) +: (NP >> l)*AW])
    );
  end

  assign final_s    = tree_s[lvl_off(LEVELS) +: AW];
  assign acc_ext_s  = NN_ACC_MAX_W'($signed(final_s));
  assign ovf_next_s = nn_ovf(acc_ext_s, W);
  assign sum_next_s = W'(nn_sat_wrap(acc_ext_s, W, SAT_EN));

  // Output register: holds sum/ovf while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      ovf_r       <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= vld_s[LEVELS];
      sum_r       <= sum_next_s;
      ovf_r       <= ovf_next_s;
    end
  end

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_weighted_sum.sv
// Self-checking bench for pipelined_weighted_sum (N=8/W=32 and N=5/W=16).
module tb_pipelined_weighted_sum;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, ovf;
  logic [7:0]   x;
  logic [255:0] w;
  logic [31:0]  sum;

  logic         in_valid5, in_ready5, out_valid5, ovf5;
  logic [4:0]   x5;
  logic [79:0]  w5;
  logic [15:0]  sum5;

  always #5 clk = ~clk;

  pipelined_weighted_sum #(.N(8), .W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w(w), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf));

  pipelined_weighted_sum #(.N(5), .W(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .x(x5), .w(w5), .out_valid(out_valid5), .out_ready(1'b1),
    .sum(sum5), .ovf(ovf5));

  typedef struct { logic [31:0] sum; logic ovf; int t; } exp_t;
  typedef struct { logic [7:0] x; logic [255:0] w; logic [31:0] sum; logic ovf; } vec_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   n_tests = 0, n_fail = 0, cyc = 0, ov_cycles = 0, n_drain = 0;
  bit   lat_chk = 1'b1;
  logic s_in_ready, s_out_valid, s_ovf;
  logic [31:0] s_sum;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer sum of the selected weights, then range rules.
  function automatic void model(input logic [7:0] xv, input logic [255:0] wv,
                                output logic [31:0] es, output logic eo);
    longint acc = 0;
    for (int i = 0; i < 8; i++)
      if (xv[i]) acc += longint'($signed(wv[32*i +: 32]));
    eo = (acc > 64'sd2147483647) || (acc < -64'sd2147483648);
`ifdef WSUM_SATURATE_EN
    if (acc > 64'sd2147483647) es = 32'h7FFFFFFF;
    else if (acc < -64'sd2147483648) es = 32'h80000000;
    else es = acc[31:0];
`else
    es = acc[31:0];
`endif
  endfunction

  function automatic logic [255:0] w_inc();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = 32'(i + 1);
    return r;
  endfunction

  function automatic logic [255:0] w_pow10();
    logic [255:0] r;
    logic [31:0]  p = 32'd1;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = p;
      p = p * 32'd10;
    end
    return r;
  endfunction

  function automatic logic [255:0] w_const(input logic [31:0] c);
    return {8{c}};
  endfunction

  function automatic logic [255:0] w_rand();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       r[32*i +: 32] = $urandom_range(0, 2000) - 32'd1000;
        1:       r[32*i +: 32] = $urandom;
        2:       r[32*i +: 32] = 32'h7FFFFFFF;
        default: r[32*i +: 32] = 32'h80000000;
      endcase
    end
    return r;
  endfunction

  // One clock cycle on the N=8 DUT: drive, sample mid-cycle, score, advance.
  task automatic cycle(input logic iv, input logic [7:0] xv, input logic [255:0] wv,
                       input logic oready, input logic [31:0] es, input logic eo);
    exp_t e;
    in_valid = iv; x = xv; w = wv; out_ready = oready;
    #2;
    s_in_ready = in_ready; s_out_valid = out_valid; s_sum = sum; s_ovf = ovf;
    if (s_out_valid) ov_cycles++;
    if (s_out_valid && oready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL spurious_output: got sum %0h with nothing expected", s_sum);
      end else begin
        e = sb.pop_front();
        n_drain++;
        check("sum", s_sum, e.sum);
        check("ovf", s_ovf, e.ovf);
        if (lat_chk) check("latency", cyc - e.t, 5);
      end
    end
    if (iv && s_in_ready) sb.push_back('{es, eo, cyc});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic oready);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 256'd0, oready, 32'd0, 1'b0);
  endtask

  task automatic send_rand(input logic oready);
    logic [7:0] xv; logic [255:0] wv; logic [31:0] es; logic eo;
    xv = 8'($urandom); wv = w_rand();
    model(xv, wv, es, eo);
    cycle(1'b1, xv, wv, oready, es, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] xv; logic [255:0] wv; logic [31:0] es; logic eo; logic [31:0] held;
    int k, lat; bit done;

    rst_n = 1'b0; in_valid = 1'b0; x = '0; w = '0; out_ready = 1'b1;
    in_valid5 = 1'b0; x5 = '0; w5 = '0;

    tbl[0] = '{8'hFF, w_inc(),   32'd36, 1'b0};
    tbl[1] = '{8'h01, w_pow10(), 32'd1, 1'b0};
    tbl[2] = '{8'h80, w_pow10(), 32'd10000000, 1'b0};
    tbl[3] = '{8'h0F, w_pow10(), 32'd1111, 1'b0};
`ifdef WSUM_SATURATE_EN
    tbl[4] = '{8'hFF, w_const(32'h7FFFFFFF), 32'h7FFFFFFF, 1'b1};
    tbl[5] = '{8'hFF, w_const(32'h80000000), 32'h80000000, 1'b1};
    tbl[6] = '{8'h03, w_const(32'h7FFFFFFF), 32'h7FFFFFFF, 1'b1};
`else
    tbl[4] = '{8'hFF, w_const(32'h7FFFFFFF), 32'hFFFFFFF8, 1'b1};
    tbl[5] = '{8'hFF, w_const(32'h80000000), 32'h00000000, 1'b1};
    tbl[6] = '{8'h03, w_const(32'h7FFFFFFF), 32'hFFFFFFFE, 1'b1};
`endif
    tbl[7] = '{8'h01, w_const(32'h7FFFFFFF), 32'h7FFFFFFF, 1'b0};
    tbl[8] = '{8'h01, w_const(32'h80000000), 32'h80000000, 1'b0};
    tbl[9] = '{8'hAA, w_inc(),   32'd20, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Test 1: single vector, latency 5, out_valid for one cycle
    lat_chk = 1'b1; ov_cycles = 0;
    cycle(1'b1, 8'hFF, w_inc(), 1'b1, 32'd36, 1'b0);
    idle(8, 1'b1);
    check("t1_out_valid_cycles", ov_cycles, 1);

    // Test 2/4: table back-to-back
    for (int i = 0; i < 10; i++)
      cycle(1'b1, tbl[i].x, tbl[i].w, 1'b1, tbl[i].sum, tbl[i].ovf);
    idle(8, 1'b1);
    check("t2_sb_empty", sb.size(), 0);

    // Test 5: N=5, W=16
    in_valid5 = 1'b1; x5 = 5'b10101;
    w5[15:0] = 16'hFFFE; w5[31:16] = 16'd100; w5[47:32] = 16'd7;
    w5[63:48] = 16'hFFFD; w5[79:64] = 16'd5;
    #2;
    check("t5_in_ready", in_ready5, 1);
    @(posedge clk); @(negedge clk);
    in_valid5 = 1'b0;
    lat = 0; done = 1'b0;
    while (!done && lat < 20) begin
      lat++;
      #2;
      if (out_valid5) done = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    check("t5_latency", lat, 5);
    check("t5_sum", sum5, 16'd10);
    check("t5_ovf", ovf5, 0);

    // Test 3: backpressure with 3 in flight
    lat_chk = 1'b0; n_drain = 0;
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    k = 0;
    do begin
      cycle(1'b0, 8'h00, 256'd0, 1'b0, 32'd0, 1'b0);
      k++;
    end while (!s_out_valid && k < 10);
    check("t3_out_valid", s_out_valid, 1);
    check("t3_in_ready_stall", s_in_ready, 0);
    held = sb.size() > 0 ? sb[0].sum : 32'd0;
    check("t3_sum_stall", s_sum, held);
    xv = 8'h3C; wv = w_rand(); model(xv, wv, es, eo);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, xv, wv, 1'b0, es, eo);
      check("t3_in_ready_held", s_in_ready, 0);
      check("t3_out_valid_held", s_out_valid, 1);
      check("t3_sum_held", s_sum, held);
    end
    k = 0;
    do begin
      cycle(1'b1, xv, wv, 1'b1, es, eo);
      k++;
    end while (!s_in_ready && k < 10);
    idle(10, 1'b1);
    check("t3_drained", n_drain, 4);
    check("t3_sb_empty", sb.size(), 0);

    // Test 6: async reset mid-flight
    for (int i = 0; i < 4; i++) send_rand(1'b0);
    k = 0;
    do begin
      cycle(1'b0, 8'h00, 256'd0, 1'b0, 32'd0, 1'b0);
      k++;
    end while (!s_out_valid && k < 10);
    check("t6_loaded", s_out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_out_valid", out_valid, 0);
    check("t6_async_in_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    sb.delete();
    ov_cycles = 0;
    idle(10, 1'b1);
    check("t6_no_stale", ov_cycles, 0);
    lat_chk = 1'b1;
    send_rand(1'b1);
    idle(8, 1'b1);
    check("t6_sb_empty", sb.size(), 0);

    // Random traffic with random backpressure
    lat_chk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      xv = 8'($urandom); wv = w_rand(); model(xv, wv, es, eo);
      cycle($urandom_range(0, 9) < 7, xv, wv, $urandom_range(0, 9) < 7, es, eo);
    end
    idle(20, 1'b1);
    check("rand_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
